// File: rtl/mem_pkg.sv
// Shared memory-side definitions: port FSM encoding, datapath widths and
// the wrap-safe instruction age compare used across the core.
package mem_pkg;
    localparam int DM_W  = 32;
    localparam int INO_W = 32;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // True when a was issued before b; stays correct across instruction-number wrap.
    function automatic logic older(input logic [INO_W-1:0] a, input logic [INO_W-1:0] b);
        return $signed(a - b) < 0;
    endfunction
endpackage

// File: rtl/age_arbiter.sv
// Picks the winner between the load and store buffers: oldest first, unless
// one side has won too many contested rounds in a row. gnt[0]=load, gnt[1]=store.
module age_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int SC_W       = 3
) (
    input  logic             ld_req,
    input  logic             st_req,
    input  logic [INO_W-1:0] ld_instrno,
    input  logic [INO_W-1:0] st_instrno,
    input  logic [SC_W-1:0]  starve_cnt,
    input  logic             last_st,
    output logic [1:0]       gnt
);
    localparam logic [SC_W-1:0] LIM = SC_W'(STARVE_LIM);

    always_comb begin
        gnt = 2'b00;
        if (ld_req && st_req) begin
            if (starve_cnt == LIM) begin
                gnt = last_st ? 2'b01 : 2'b10;
            end else if (older(ld_instrno, st_instrno)) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (ld_req) begin
            gnt = 2'b01;
        end else if (st_req) begin
            gnt = 2'b10;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the load and store buffers,
// runs the variable-latency handshake with a timeout, and reports completions.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_req,
    input  logic [INO_W-1:0] ld_instrno,
    input  logic [DM_W-1:0]  ld_addr,
    input  logic [REG_W-1:0] ld_rt,
    output logic             ld_gnt,
    input  logic             st_req,
    input  logic [INO_W-1:0] st_instrno,
    input  logic [DM_W-1:0]  st_addr,
    input  logic [DM_W-1:0]  st_data,
    output logic             st_gnt,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DM_W-1:0]  dm_addr,
    output logic [DM_W-1:0]  dm_wdata,
    input  logic             dm_ack,
    input  logic [DM_W-1:0]  dm_rdata,
    output logic             ld_done,
    output logic [INO_W-1:0] ld_done_instrno,
    output logic [REG_W-1:0] ld_done_rt,
    output logic [DM_W-1:0]  ld_done_data,
    output logic             st_done,
    output logic [INO_W-1:0] st_done_instrno,
    output logic             dm_err,
    output logic             busy
);
    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state;
    mem_state_t       state_nx;
    logic [1:0]       win;
    logic             idle;
    logic             contested;
    logic             acked;
    logic             aborted;
    logic [SC_W-1:0]  starve_cnt;
    logic             last_st;
    logic [CNT_W-1:0] to_cnt;
    logic [INO_W-1:0] lat_instrno;
    logic [REG_W-1:0] lat_rt;

    age_arbiter #(
        .STARVE_LIM(STARVE_LIM),
        .SC_W      (SC_W)
    ) u_age_arbiter (
        .ld_req    (ld_req),
        .st_req    (st_req),
        .ld_instrno(ld_instrno),
        .st_instrno(st_instrno),
        .starve_cnt(starve_cnt),
        .last_st   (last_st),
        .gnt       (win)
    );

    // No grant while held in reset: the buffer would retire an entry nobody latches.
    assign idle      = (state == IDLE) && rst;
    assign ld_gnt    = idle && win[0];
    assign st_gnt    = idle && win[1];
    assign contested = ld_req && st_req;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acked    = 1'b0;
        aborted  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_gnt) begin
                    state_nx = LD_WAIT;
                end else if (st_gnt) begin
                    state_nx = ST_WAIT;
                end
            end
            LD_WAIT, ST_WAIT: begin
                if (dm_ack) begin
                    state_nx = IDLE;
                    acked    = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = IDLE;
                    aborted  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only contested grants feed the fairness history; an uncontested grant clears the streak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            last_st    <= 1'b0;
        end else if (ld_gnt || st_gnt) begin
            if (contested) begin
                starve_cnt <= (st_gnt == last_st) ? starve_cnt + 1'b1 : SC_W'(1);
                last_st    <= st_gnt;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req          <= 1'b0;
            dm_we           <= 1'b0;
            dm_addr         <= '0;
            dm_wdata        <= '0;
            lat_instrno     <= '0;
            lat_rt          <= '0;
            to_cnt          <= '0;
            ld_done         <= 1'b0;
            ld_done_instrno <= '0;
            ld_done_rt      <= '0;
            ld_done_data    <= '0;
            st_done         <= 1'b0;
            st_done_instrno <= '0;
            dm_err          <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            st_done <= 1'b0;
            dm_err  <= 1'b0;
            if (ld_gnt || st_gnt) begin
                dm_req      <= 1'b1;
                dm_we       <= st_gnt;
                dm_addr     <= st_gnt ? st_addr : ld_addr;
                dm_wdata    <= st_gnt ? st_data : '0;
                lat_instrno <= st_gnt ? st_instrno : ld_instrno;
                lat_rt      <= st_gnt ? '0 : ld_rt;
                to_cnt      <= '0;
            end else if (acked) begin
                dm_req <= 1'b0;
                if (state == LD_WAIT) begin
                    ld_done         <= 1'b1;
                    ld_done_instrno <= lat_instrno;
                    ld_done_rt      <= lat_rt;
                    ld_done_data    <= dm_rdata;
                end else begin
                    st_done         <= 1'b1;
                    st_done_instrno <= lat_instrno;
                end
            end else if (aborted) begin
                dm_req <= 1'b0;
                dm_err <= 1'b1;
                to_cnt <= to_cnt + 1'b1;
            end else if (busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;
    localparam int STARVE_LIM = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [31:0] ld_instrno;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rt;
    logic        ld_gnt;
    logic        st_req;
    logic [31:0] st_instrno;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_gnt;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        ld_done;
    logic [31:0] ld_done_instrno;
    logic [4:0]  ld_done_rt;
    logic [31:0] ld_done_data;
    logic        st_done;
    logic [31:0] st_done_instrno;
    logic        dm_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .STARVE_LIM(STARVE_LIM),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_req         (ld_req),
        .ld_instrno     (ld_instrno),
        .ld_addr        (ld_addr),
        .ld_rt          (ld_rt),
        .ld_gnt         (ld_gnt),
        .st_req         (st_req),
        .st_instrno     (st_instrno),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_gnt         (st_gnt),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_ack         (dm_ack),
        .dm_rdata       (dm_rdata),
        .ld_done        (ld_done),
        .ld_done_instrno(ld_done_instrno),
        .ld_done_rt     (ld_done_rt),
        .ld_done_data   (ld_done_data),
        .st_done        (st_done),
        .st_done_instrno(st_done_instrno),
        .dm_err         (dm_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access record in flight plus the history of contested winners.
    typedef struct {
        bit          is_st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ino;
        logic [4:0]  rt;
    } access_t;

    access_t     cur;
    bit          m_busy;
    int          m_wait;
    bit          e_ld_done;
    bit          e_st_done;
    bit          e_err;
    logic [31:0] e_ld_ino;
    logic [31:0] e_ld_data;
    logic [4:0]  e_ld_rt;
    logic [31:0] e_st_ino;
    bit          hist[$];

    function automatic bit starved();
        if (hist.size() < STARVE_LIM) return 1'b0;
        for (int i = hist.size() - STARVE_LIM; i < hist.size(); i++) begin
            if (hist[i] != hist[hist.size() - 1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_wait    = 0;
        e_ld_done = 1'b0;
        e_st_done = 1'b0;
        e_err     = 1'b0;
        hist.delete();
    endtask

    always @(negedge clk) begin : model_cmp
        bit win_ld;
        bit win_st;
        if (!rst) model_reset();
        win_ld = 1'b0;
        win_st = 1'b0;
        if (rst && !m_busy) begin
            if (ld_req && st_req) begin
                if (starved()) win_st = !hist[hist.size() - 1];
                else           win_st = !(int'(ld_instrno - st_instrno) < 0);
                win_ld = !win_st;
            end else begin
                win_ld = ld_req;
                win_st = st_req;
            end
        end
        check_output("ld_gnt", 32'(ld_gnt), 32'(win_ld));
        check_output("st_gnt", 32'(st_gnt), 32'(win_st));
        check_output("dm_req", 32'(dm_req), 32'(m_busy));
        check_output("busy", 32'(busy), 32'(m_busy));
        if (m_busy) begin
            check_output("dm_we", 32'(dm_we), 32'(cur.is_st));
            check_output("dm_addr", dm_addr, cur.addr);
            check_output("dm_wdata", dm_wdata, cur.wdata);
        end
        check_output("ld_done", 32'(ld_done), 32'(e_ld_done));
        check_output("st_done", 32'(st_done), 32'(e_st_done));
        check_output("dm_err", 32'(dm_err), 32'(e_err));
        if (e_ld_done) begin
            check_output("ld_done_instrno", ld_done_instrno, e_ld_ino);
            check_output("ld_done_rt", 32'(ld_done_rt), 32'(e_ld_rt));
            check_output("ld_done_data", ld_done_data, e_ld_data);
        end
        if (e_st_done) check_output("st_done_instrno", st_done_instrno, e_st_ino);

        e_ld_done = 1'b0;
        e_st_done = 1'b0;
        e_err     = 1'b0;
        if (rst) begin
            if (!m_busy) begin
                if (win_ld || win_st) begin
                    cur.is_st = win_st;
                    cur.addr  = win_st ? st_addr : ld_addr;
                    cur.wdata = win_st ? st_data : 32'd0;
                    cur.ino   = win_st ? st_instrno : ld_instrno;
                    cur.rt    = ld_rt;
                    m_busy    = 1'b1;
                    m_wait    = 0;
                    if (ld_req && st_req) begin
                        hist.push_back(win_st);
                        if (hist.size() > STARVE_LIM) void'(hist.pop_front());
                    end else begin
                        hist.delete();
                    end
                end
            end else if (dm_ack) begin
                m_busy = 1'b0;
                if (cur.is_st) begin
                    e_st_done = 1'b1;
                    e_st_ino  = cur.ino;
                end else begin
                    e_ld_done = 1'b1;
                    e_ld_ino  = cur.ino;
                    e_ld_rt   = cur.rt;
                    e_ld_data = dm_rdata;
                end
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    e_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ld_req     = 1'b0;
        ld_instrno = 32'd0;
        ld_addr    = 32'd0;
        ld_rt      = 5'd0;
        st_req     = 1'b0;
        st_instrno = 32'd0;
        st_addr    = 32'd0;
        st_data    = 32'd0;
        dm_ack     = 1'b0;
        dm_rdata   = 32'd0;
    endtask

    task automatic apply_stimulus(input int cyc);
        logic [31:0] base;
        base   = 32'hFFFF_FF00 + 32'(cyc);
        rst    = ($urandom_range(0, 499) != 0);
        ld_req = ($urandom_range(0, 3) != 0);
        st_req = ($urandom_range(0, 3) != 0);
        case ((cyc / 60) % 3)
            0: begin
                ld_instrno = base + 32'($urandom_range(0, 7));
                st_instrno = base + 32'($urandom_range(0, 7));
            end
            1: begin
                ld_instrno = base;
                st_instrno = base + 32'd5;
            end
            default: begin
                ld_instrno = base + 32'd5;
                st_instrno = base;
            end
        endcase
        ld_addr  = $urandom();
        ld_rt    = 5'($urandom());
        st_addr  = $urandom();
        st_data  = $urandom();
        dm_ack   = ($urandom_range(0, 2) == 0);
        dm_rdata = $urandom();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int gnt_cnt;
        int done_cnt;
        int last_gnt;
        int req_cycles;
        int err_cnt;
        bit saw;
        bit got_ld;
        bit got_st;
        bit gnt_at_err;

        rst = 1'b0;
        clear_inputs();
        ld_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check_output("rst_dm_req", 32'(dm_req), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_dm_addr", dm_addr, 32'd0);
        ld_req = 1'b0;
        rst    = 1'b1;
        step();
        step();

        // Reset in the middle of a load access.
        ld_req = 1'b1; ld_instrno = 32'd5; ld_addr = 32'h40; ld_rt = 5'd3;
        step();
        ld_req = 1'b0;
        check_output("t1_dm_req_before", 32'(dm_req), 32'd1);
        rst = 1'b0;
        #1;
        check_output("t1_dm_req_async", 32'(dm_req), 32'd0);
        check_output("t1_busy_async", 32'(busy), 32'd0);
        step();
        rst    = 1'b1;
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        check_output("t1_no_ld_done", 32'(ld_done), 32'd0);
        check_output("t1_idle", 32'(busy), 32'd0);
        step();

        // Age order, ack three cycles after the grant.
        ld_req = 1'b1; ld_instrno = 32'd10; ld_rt = 5'd7; ld_addr = 32'h100;
        st_req = 1'b1; st_instrno = 32'd12; st_addr = 32'h200; st_data = 32'h55;
        @(negedge clk);
        check_output("t2_ld_gnt", 32'(ld_gnt), 32'd1);
        check_output("t2_st_gnt", 32'(st_gnt), 32'd0);
        step();
        ld_req = 1'b0;
        st_req = 1'b0;
        step();
        step();
        dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
        step();
        dm_ack = 1'b0;
        check_output("t2_ld_done", 32'(ld_done), 32'd1);
        check_output("t2_ld_data", ld_done_data, 32'hCAFE_F00D);
        check_output("t2_ld_rt", 32'(ld_done_rt), 32'd7);
        check_output("t2_ld_ino", ld_done_instrno, 32'd10);
        step();

        // Instruction-number wrap: the store is the older one.
        ld_req = 1'b1; ld_instrno = 32'h0000_0002;
        st_req = 1'b1; st_instrno = 32'hFFFF_FFFE; st_addr = 32'h300; st_data = 32'h77;
        @(negedge clk);
        check_output("t3_st_gnt", 32'(st_gnt), 32'd1);
        check_output("t3_ld_gnt", 32'(ld_gnt), 32'd0);
        step();
        ld_req = 1'b0;
        st_req = 1'b0;
        check_output("t3_dm_we", 32'(dm_we), 32'd1);
        check_output("t3_dm_wdata", dm_wdata, 32'h77);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        check_output("t3_st_done", 32'(st_done), 32'd1);
        check_output("t3_st_ino", st_done_instrno, 32'hFFFF_FFFE);
        step();

        // Starvation: four older loads win, the fifth contested round goes to the store.
        st_req = 1'b1; st_instrno = 32'd1000; st_addr = 32'h400; st_data = 32'h99;
        for (int k = 0; k < 5; k++) begin
            ld_req = 1'b1; ld_instrno = 32'(100 + k); ld_addr = 32'h500 + 32'(k); ld_rt = 5'(k);
            @(negedge clk);
            got_ld = ld_gnt;
            got_st = st_gnt;
            check_output("t4_st_wins", 32'(st_gnt), 32'(k == 4));
            step();
            if (got_ld) ld_req = 1'b0;
            if (got_st) st_req = 1'b0;
            dm_ack = 1'b1;
            step();
            dm_ack = 1'b0;
        end
        clear_inputs();
        step();

        // Timeout: no ack after a load grant, store pending behind it.
        ld_req = 1'b1; ld_instrno = 32'd50; ld_addr = 32'h600; ld_rt = 5'd9;
        step();
        ld_req = 1'b0;
        st_req = 1'b1; st_instrno = 32'd60; st_addr = 32'h700; st_data = 32'h1234;
        req_cycles = 0; err_cnt = 0; gnt_at_err = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            saw = st_gnt;
            if (err_cnt == 0 && dm_req) req_cycles++;
            if (dm_err) begin
                err_cnt++;
                gnt_at_err = st_gnt;
            end
            step();
            if (saw) st_req = 1'b0;
        end
        check_output("t5_req_cycles", 32'(req_cycles), 32'd64);
        check_output("t5_err_pulses", 32'(err_cnt), 32'd1);
        check_output("t5_next_gnt", 32'(gnt_at_err), 32'd1);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        check_output("t5_st_done", 32'(st_done), 32'd1);
        clear_inputs();
        step();

        // Back-to-back loads with a one-cycle ack.
        idx = 0; gnt_cnt = 0; done_cnt = 0; last_gnt = 0;
        ld_req = 1'b1; ld_instrno = 32'd200; ld_rt = 5'd0; ld_addr = 32'h1000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            saw = ld_gnt;
            if (ld_gnt) begin
                if (gnt_cnt > 0) check_output("t6_gap", 32'(c - last_gnt), 32'd2);
                last_gnt = c;
                gnt_cnt++;
            end
            if (ld_done) begin
                check_output("t6_order", ld_done_instrno, 32'(200 + done_cnt));
                done_cnt++;
            end
            step();
            dm_ack = saw;
            if (saw) begin
                idx++;
                ld_req     = (idx < 4);
                ld_instrno = 32'(200 + idx);
                ld_rt      = 5'(idx);
                ld_addr    = 32'h1000 + 32'(4 * idx);
            end
        end
        check_output("t6_gnts", 32'(gnt_cnt), 32'd4);
        check_output("t6_dones", 32'(done_cnt), 32'd4);
        clear_inputs();
        step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            apply_stimulus(cyc);
            step();
        end
        rst = 1'b1;
        clear_inputs();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
